// File: rtl/arbitro_memoria_datos_if.sv
// Bus bundle between the data-memory arbiter and its two requesters plus the memory.
// Signal names keep their arbiter-side direction prefixes so both ends read the same.
interface arbitro_memoria_datos_if;
  // Port A (pipeline MEM stage)
  logic        i_req_a;
  logic        i_we_a;
  logic [31:0] i_addr_a;
  logic [31:0] i_wdata_a;
  logic        o_gnt_a;
  logic        o_valid_a;
  logic        o_err_a;
  logic [31:0] o_rdata_a;

  // Port B (loader/debug)
  logic        i_req_b;
  logic        i_we_b;
  logic [31:0] i_addr_b;
  logic [31:0] i_wdata_b;
  logic        o_gnt_b;
  logic        o_valid_b;
  logic        o_err_b;
  logic [31:0] o_rdata_b;

  // Memory side
  logic        o_mem_r;
  logic        o_mem_w;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_rdata;

  // Status
  logic        o_ocupado;

  // Arbiter side
  modport slave (
    input  i_req_a, i_we_a, i_addr_a, i_wdata_a,
    input  i_req_b, i_we_b, i_addr_b, i_wdata_b,
    input  i_mem_rdata,
    output o_gnt_a, o_valid_a, o_err_a, o_rdata_a,
    output o_gnt_b, o_valid_b, o_err_b, o_rdata_b,
    output o_mem_r, o_mem_w, o_mem_addr, o_mem_data,
    output o_ocupado
  );

  // Requesters and memory side
  modport master (
    output i_req_a, i_we_a, i_addr_a, i_wdata_a,
    output i_req_b, i_we_b, i_addr_b, i_wdata_b,
    output i_mem_rdata,
    input  o_gnt_a, o_valid_a, o_err_a, o_rdata_a,
    input  o_gnt_b, o_valid_b, o_err_b, o_rdata_b,
    input  o_mem_r, o_mem_w, o_mem_addr, o_mem_data,
    input  o_ocupado
  );
endinterface

// File: rtl/arbitro_memoria_datos.sv
// Round-robin arbiter/sequencer sharing the data memory between port A and port B.
// Each access takes three cycles: grant + strobe, valid + data, then back to idle.
// Every output comes straight from a register.
module arbitro_memoria_datos #(
  parameter int unsigned PALABRAS = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  arbitro_memoria_datos_if.slave  bus
);

  typedef enum logic [1:0] {
    StLibre,
    StAcceso,
    StResp
  } estado_e;

  estado_e estado_q, estado_d;

  // Port encoding for ultimo/winner: 0 = A, 1 = B
  logic        ultimo_q, ultimo_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        rng_q, rng_d;

  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        valid_a_q, valid_a_d;
  logic        valid_b_q, valid_b_d;
  logic        err_a_q, err_a_d;
  logic        err_b_q, err_b_d;
  logic [31:0] rdata_a_q, rdata_a_d;
  logic [31:0] rdata_b_q, rdata_b_d;
  logic        mem_r_q, mem_r_d;
  logic        mem_w_q, mem_w_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        ocupado_q, ocupado_d;

  // Winner selection signals for the LIBRE decision
  logic        pick_b;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_rng;

  // Pick the winner: on conflict the port not served last wins; a lone requester always wins.
  always_comb begin
    pick_b    = bus.i_req_b && (!bus.i_req_a || !ultimo_q);
    sel_we    = pick_b ? bus.i_we_b    : bus.i_we_a;
    sel_addr  = pick_b ? bus.i_addr_b  : bus.i_addr_a;
    sel_wdata = pick_b ? bus.i_wdata_b : bus.i_wdata_a;
    // Full 32-bit unsigned compare so high address bits are never ignored
    sel_rng   = (sel_addr < 32'(PALABRAS));
  end

  // Next-state and registered-output values.
  always_comb begin
    estado_d   = estado_q;
    ultimo_d   = ultimo_q;
    win_d      = win_q;
    we_d       = we_q;
    rng_d      = rng_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    valid_a_d  = 1'b0;
    valid_b_d  = 1'b0;
    err_a_d    = 1'b0;
    err_b_d    = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    mem_r_d    = 1'b0;
    mem_w_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    unique case (estado_q)
      StLibre: begin
        if (bus.i_req_a || bus.i_req_b) begin
          win_d      = pick_b;
          ultimo_d   = pick_b;
          we_d       = sel_we;
          rng_d      = sel_rng;
          gnt_a_d    = !pick_b;
          gnt_b_d    = pick_b;
          // The latched address/data are held on the memory bus for the whole ACCESO cycle
          mem_addr_d = sel_addr;
          mem_data_d = sel_wdata;
          mem_r_d    = sel_rng && !sel_we;
          mem_w_d    = sel_rng && sel_we;
          estado_d   = StAcceso;
        end
      end

      StAcceso: begin
        // Memory data is captured on the edge that leaves ACCESO
        if (win_q) begin
          valid_b_d = 1'b1;
          err_b_d   = !rng_q;
          if (!we_q) begin
            rdata_b_d = rng_q ? bus.i_mem_rdata : 32'h0;
          end
        end else begin
          valid_a_d = 1'b1;
          err_a_d   = !rng_q;
          if (!we_q) begin
            rdata_a_d = rng_q ? bus.i_mem_rdata : 32'h0;
          end
        end
        estado_d = StResp;
      end

      StResp: begin
        estado_d = StLibre;
      end

      default: begin
        estado_d = StLibre;
      end
    endcase

    ocupado_d = (estado_d != StLibre);
  end

  // State and output registers with synchronous reset; a reset mid-access drops it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      estado_q   <= StLibre;
      ultimo_q   <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      rng_q      <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
      rdata_a_q  <= 32'h0;
      rdata_b_q  <= 32'h0;
      mem_r_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_data_q <= 32'h0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ultimo_q   <= ultimo_d;
      win_q      <= win_d;
      we_q       <= we_d;
      rng_q      <= rng_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      valid_a_q  <= valid_a_d;
      valid_b_q  <= valid_b_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      mem_r_q    <= mem_r_d;
      mem_w_q    <= mem_w_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.o_gnt_a    = gnt_a_q;
  assign bus.o_gnt_b    = gnt_b_q;
  assign bus.o_valid_a  = valid_a_q;
  assign bus.o_valid_b  = valid_b_q;
  assign bus.o_err_a    = err_a_q;
  assign bus.o_err_b    = err_b_q;
  assign bus.o_rdata_a  = rdata_a_q;
  assign bus.o_rdata_b  = rdata_b_q;
  assign bus.o_mem_r    = mem_r_q;
  assign bus.o_mem_w    = mem_w_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;
  assign bus.o_ocupado  = ocupado_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed bench for arbitro_memoria_datos: table of single accesses plus hand-written
// sequences for conflicts, reset mid-access and a dropped losing request.
module tb_arbitro_memoria_datos;

  logic clk;
  logic rst;
  logic cargar;

  int checks;
  int failures;

  arbitro_memoria_datos_if bus ();

  arbitro_memoria_datos #(
    .PALABRAS (32)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-word memory, word i preloaded with 5*i. It ignores the strobe while reset is held,
  // so an access aborted by reset leaves the memory untouched.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (cargar) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i * 5);
    end else if (bus.o_mem_w && !rst) begin
      mem[bus.o_mem_addr[4:0]] <= bus.o_mem_data;
    end
  end
  assign bus.i_mem_rdata = mem[bus.o_mem_addr[4:0]];

  typedef struct {
    logic        port_b;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tabla [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req_a   = 1'b0;
    bus.i_we_a    = 1'b0;
    bus.i_addr_a  = 32'h0;
    bus.i_wdata_a = 32'h0;
    bus.i_req_b   = 1'b0;
    bus.i_we_b    = 1'b0;
    bus.i_addr_b  = 32'h0;
    bus.i_wdata_b = 32'h0;
  endtask

  // All outputs at their reset values
  task automatic chk_reposo(input string tag);
    chk({tag, " gnt_a"},    32'(bus.o_gnt_a),   32'h0);
    chk({tag, " gnt_b"},    32'(bus.o_gnt_b),   32'h0);
    chk({tag, " valid_a"},  32'(bus.o_valid_a), 32'h0);
    chk({tag, " valid_b"},  32'(bus.o_valid_b), 32'h0);
    chk({tag, " err_a"},    32'(bus.o_err_a),   32'h0);
    chk({tag, " err_b"},    32'(bus.o_err_b),   32'h0);
    chk({tag, " mem_r"},    32'(bus.o_mem_r),   32'h0);
    chk({tag, " mem_w"},    32'(bus.o_mem_w),   32'h0);
    chk({tag, " ocupado"},  32'(bus.o_ocupado), 32'h0);
    chk({tag, " mem_addr"}, bus.o_mem_addr,     32'h0);
    chk({tag, " mem_data"}, bus.o_mem_data,     32'h0);
    chk({tag, " rdata_a"},  bus.o_rdata_a,      32'h0);
    chk({tag, " rdata_b"},  bus.o_rdata_b,      32'h0);
  endtask

  // Reset for two edges; returns at a falling edge in LIBRE
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One access from a table record; called at a falling edge in LIBRE, returns in LIBRE
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    logic  in_rng;
    t      = $sformatf("v%0d", idx);
    in_rng = !v.exp_err;
    if (v.port_b) begin
      bus.i_req_b = 1'b1; bus.i_we_b = v.we; bus.i_addr_b = v.addr; bus.i_wdata_b = v.wdata;
    end else begin
      bus.i_req_a = 1'b1; bus.i_we_a = v.we; bus.i_addr_a = v.addr; bus.i_wdata_a = v.wdata;
    end
    @(negedge clk);  // T+1: ACCESO
    chk({t, " gnt_a"},    32'(bus.o_gnt_a), 32'(!v.port_b));
    chk({t, " gnt_b"},    32'(bus.o_gnt_b), 32'(v.port_b));
    chk({t, " mem_r"},    32'(bus.o_mem_r), 32'(in_rng && !v.we));
    chk({t, " mem_w"},    32'(bus.o_mem_w), 32'(in_rng && v.we));
    chk({t, " mem_addr"}, bus.o_mem_addr,   v.addr);
    chk({t, " mem_data"}, bus.o_mem_data,   v.wdata);
    chk({t, " ocupado"},  32'(bus.o_ocupado), 32'h1);
    idle_inputs();
    @(negedge clk);  // T+2: RESP
    chk({t, " valid_a"},  32'(bus.o_valid_a), 32'(!v.port_b));
    chk({t, " valid_b"},  32'(bus.o_valid_b), 32'(v.port_b));
    chk({t, " err"},      32'(v.port_b ? bus.o_err_b : bus.o_err_a), 32'(v.exp_err));
    chk({t, " rdata"},    v.port_b ? bus.o_rdata_b : bus.o_rdata_a, v.exp_rdata);
    chk({t, " strobe_off"}, 32'({bus.o_mem_r, bus.o_mem_w}), 32'h0);
    chk({t, " gnt_off"},  32'({bus.o_gnt_a, bus.o_gnt_b}), 32'h0);
    @(negedge clk);  // T+3: LIBRE
    chk({t, " valid_off"}, 32'({bus.o_valid_a, bus.o_valid_b}), 32'h0);
    chk({t, " libre"},    32'(bus.o_ocupado), 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    cargar = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    do_reset();
    chk_reposo("reset");

    //           port we  addr            wdata         err  rdata after
    tabla[0] = '{1'b0, 1'b0, 32'd3,          32'h0,        1'b0, 32'd15};
    tabla[1] = '{1'b1, 1'b1, 32'd7,          32'hDEADBEEF, 1'b0, 32'h0};
    tabla[2] = '{1'b1, 1'b0, 32'd7,          32'h0,        1'b0, 32'hDEADBEEF};
    tabla[3] = '{1'b0, 1'b0, 32'd32,         32'h0,        1'b1, 32'h0};
    tabla[4] = '{1'b0, 1'b0, 32'd31,         32'h0,        1'b0, 32'd155};
    tabla[5] = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'h11,       1'b1, 32'd155};
    tabla[6] = '{1'b0, 1'b1, 32'd31,         32'hCAFE0001, 1'b0, 32'd155};
    tabla[7] = '{1'b0, 1'b0, 32'd31,         32'h0,        1'b0, 32'hCAFE0001};
    tabla[8] = '{1'b1, 1'b0, 32'd3,          32'h0,        1'b0, 32'd15};
    tabla[9] = '{1'b1, 1'b0, 32'h80000003,   32'h0,        1'b1, 32'h0};

    for (int i = 0; i < 10; i++) run_vec(i, tabla[i]);

    // Conflict: both ports request continuously; grants alternate A, B, A, B every 3 cycles
    do_reset();
    bus.i_req_a = 1'b1; bus.i_addr_a = 32'd1;
    bus.i_req_b = 1'b1; bus.i_addr_b = 32'd2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr k%0d gnt_a", k), 32'(bus.o_gnt_a), 32'((k % 6) == 1));
      chk($sformatf("rr k%0d gnt_b", k), 32'(bus.o_gnt_b), 32'((k % 6) == 4));
    end
    idle_inputs();
    @(negedge clk);
    chk("rr stop", 32'({bus.o_gnt_a, bus.o_gnt_b}), 32'h0);
    chk("rr rdata_a", bus.o_rdata_a, 32'd5);
    chk("rr rdata_b", bus.o_rdata_b, 32'd10);

    // Reset during ACCESO of a write to word 5: access dropped, word 5 keeps 25
    bus.i_req_a = 1'b1; bus.i_we_a = 1'b1; bus.i_addr_a = 32'd5; bus.i_wdata_a = 32'h12345678;
    @(negedge clk);
    chk("rst_mid mem_w", 32'(bus.o_mem_w), 32'h1);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk_reposo("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid no_valid", 32'({bus.o_valid_a, bus.o_valid_b}), 32'h0);
    chk("rst_mid libre", 32'(bus.o_ocupado), 32'h0);
    run_vec(20, '{1'b0, 1'b0, 32'd5, 32'h0, 1'b0, 32'd25});

    // Losing request pulsed only while A is granted: never served
    bus.i_req_a = 1'b1; bus.i_addr_a = 32'd2;
    @(negedge clk);
    chk("drop gnt_a", 32'(bus.o_gnt_a), 32'h1);
    idle_inputs();
    bus.i_req_b = 1'b1; bus.i_addr_b = 32'd4;
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop k%0d gnt_b", k), 32'(bus.o_gnt_b), 32'h0);
    end

    // Held loser: A wins the conflict after reset, B stays pending and is served next
    do_reset();
    bus.i_req_a = 1'b1; bus.i_addr_a = 32'd2;
    bus.i_req_b = 1'b1; bus.i_addr_b = 32'd4;
    @(negedge clk);
    chk("held gnt_a", 32'(bus.o_gnt_a), 32'h1);
    chk("held gnt_b0", 32'(bus.o_gnt_b), 32'h0);
    bus.i_req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held gnt_b1", 32'(bus.o_gnt_b), 32'h0);
    @(negedge clk);
    chk("held gnt_b", 32'(bus.o_gnt_b), 32'h1);
    chk("held mem_addr", bus.o_mem_addr, 32'd4);
    bus.i_req_b = 1'b0;
    @(negedge clk);
    chk("held valid_b", 32'(bus.o_valid_b), 32'h1);
    chk("held rdata_b", bus.o_rdata_b, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Invariants checked every cycle away from the clock edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_gnt_a && bus.o_gnt_b) begin
        failures++;
        $display("FAIL both_gnt: got 1 expected 0");
      end
      if (bus.o_mem_r && bus.o_mem_w) begin
        failures++;
        $display("FAIL both_strobes: got 1 expected 0");
      end
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
